muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle multiply/divide controller beside the single-cycle ALU in the EX stage of the pipeline CPU.
- Sequences an iterative shift-add multiplier and a restoring divider over WIDTH cycles, and owns the HI/LO architectural registers.
- Raises a stall to the hazard unit while a result is pending.
- Serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.

Parameters:
WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  issue request; sampled only in IDLE
op  in  3  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (ignored)
src0  in  WIDTH  multiplicand / dividend / MTHI-MTLO data
src1  in  WIDTH  multiplier / divisor
cancel  in  1  pipeline flush; aborts the in-flight operation
hilo_rd  in  1  EX instruction is MFHI/MFLO
busy  out  1  operation in flight
done  out  1  one-cycle pulse: HI/LO just updated by a mul/div
stall  out  1  combinational: busy & (start | hilo_rd)
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, active-high) forces: state IDLE; busy=0; done=0; hi=0; lo=0; iteration counter=0. Reset asserted mid-operation discards the operation immediately.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start=1:
  - op 1/2 -> MUL.
  - op 3/4 with src1 != 0 -> DIV.
  - op 3/4 with src1 == 0 -> FIX directly (divide-by-zero path).
  - op 5 writes hi=src0 at that edge; op 6 writes lo=src0. Both take one cycle, do not assert busy and do not pulse done.
  - op 0/7: no effect.
- Operand latch at issue:
  - Signed ops (MULT, DIV) latch magnitudes of src0 and src1 plus two sign flags.
  - Unsigned ops latch the raw operands.
  - The counter loads WIDTH.
- MUL: each cycle, if multiplier LSB=1 add multiplicand into the upper accumulator half, then shift the 2*WIDTH accumulator right one bit. The counter decrements; at 1 -> FIX.
- DIV: each cycle, shift {rem,quot} left one bit, trial-subtract the divisor, and keep the result if non-negative with the quotient bit set. The counter decrements; at 1 -> FIX.
- FIX (one cycle): apply sign correction, write hi/lo, pulse done, then -> IDLE.
  - MULT: product negated when the sign flags differ.
  - DIV: quotient negated when the signs differ; remainder takes the dividend's sign.
  - Divide by zero: hi=src0 as latched (original, unsigned view), lo={WIDTH{1}}.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Result placement: MUL -> hi=upper half, lo=lower half. DIV -> lo=quotient, hi=remainder.
- Latency: start sampled at edge E.
  - Normal ops: busy=1 from E, done=1 and hi/lo valid after edge E+WIDTH+1, busy=0 in that same cycle (34 cycles for WIDTH=32).
  - Divide by zero: done after edge E+1.
- busy is high in MUL, DIV and FIX. start while busy is ignored; the stall output holds the issuing instruction.
- hilo_rd while busy -> stall=1. hilo_rd in the done cycle -> no stall, and the new hi/lo are visible.
- cancel in MUL/DIV/FIX -> IDLE at the next edge, hi/lo unchanged, no done.
- cancel with start in IDLE: cancel wins; nothing issues, MTHI/MTLO included.
- The signed magnitude of the most negative value wraps to 0x80000000 and is treated as unsigned WIDTH bits. No overflow flag is produced.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- When defined: in MUL, if the remaining multiplier bits are all zero, shift the accumulator by the remaining count in one step and go to FIX next cycle. MULT 5*0 completes (done) two cycles after issue; DIV latency is unchanged.
- When undefined: fixed latency WIDTH+2 for all non-zero-divisor operations.

Test Plan:
- MULT src0=0xFFFFFFFF, src1=2 -> done at edge E+33, hi=0xFFFFFFFF, lo=0xFFFFFFFE; busy=1 for cycles E..E+32.
- MULTU src0=0xFFFFFFFF, src1=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV src0=0xFFFFFFF9 (-7), src1=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU src0=100, src1=0 -> done after E+1, hi=100, lo=0xFFFFFFFF.
- MTHI 0x1234 while idle -> hi=0x1234 next edge, done=0. MFHI (hilo_rd=1) during MULT busy -> stall=1 until the done cycle.
- cancel at E+10 of a MULT -> IDLE, hi/lo keep prior values, no done. Reset at E+5 -> all outputs 0 immediately.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Bundle of request/response signals between the EX stage and the
// multiply/divide sequencer. The pipeline side uses the master modport,
// the sequencer uses the slave modport.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] src0;
  logic [WIDTH-1:0] src1;
  logic             cancel;
  logic             hilo_rd;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src0, src1, cancel, hilo_rd,
    input  busy, done, stall, hi, lo
  );

  modport slave (
    input  start, op, src0, src1, cancel, hilo_rd,
    output busy, done, stall, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer for the EX stage. Runs a shift-add
// multiplier and a restoring divider over WIDTH iterations and owns HI/LO.
// Optional macro MULDIV_EARLY_OUT_EN: the multiplier finishes early once the
// remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for an issue; MTHI/MTLO complete here in one cycle
// MUL   | shift-add iterations, counter counts down from WIDTH
// DIV   | restoring-divide iterations, counter counts down from WIDTH
// FIX   | sign correction, HI/LO write, done pulse
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // MUL: {partial product high, multiplier/product low}; DIV: {rem, quot}
  logic [2*WIDTH-1:0] acc_q, acc_d;
  // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_mul_q, is_mul_d;
  logic               dz_q, dz_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               is_signed;
  logic               sign0, sign1;
  logic [WIDTH-1:0]   src0_mag, src1_mag;

  // Signed ops work on magnitudes; the most negative value maps onto itself
  // and is then read as an unsigned WIDTH-bit magnitude.
  assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign sign0     = is_signed & bus.src0[WIDTH-1];
  assign sign1     = is_signed & bus.src1[WIDTH-1];
  assign src0_mag  = sign0 ? -bus.src0 : bus.src0;
  assign src1_mag  = sign1 ? -bus.src1 : bus.src1;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  // One shift-add step; the carry out of the add shifts into the top bit.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // One restoring step; the borrow bit of the trial subtract is the sign.
  assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opb_q};
  assign div_next  = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MULDIV_EARLY_OUT_EN
  logic [CW-1:0] bits_done;
  logic          mul_rest_zero;

  // Remaining multiplier bits sit in the low cnt_q bits of the low half.
  assign bits_done     = CW'(WIDTH) - cnt_q;
  assign mul_rest_zero = (acc_q[WIDTH-1:0] << bits_done) == '0;
`endif

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_mul_d  = is_mul_q;
    dz_d      = dz_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.cancel) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              acc_d     = {{WIDTH{1'b0}}, src1_mag};
              opb_d     = src0_mag;
              neg_res_d = sign0 ^ sign1;
              neg_rem_d = 1'b0;
              is_mul_d  = 1'b1;
              dz_d      = 1'b0;
              cnt_d     = CW'(WIDTH);
              state_d   = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
              is_mul_d  = 1'b0;
              cnt_d     = CW'(WIDTH);
              neg_res_d = sign0 ^ sign1;
              neg_rem_d = sign0;
              opb_d     = src1_mag;
              if (bus.src1 == '0) begin
                // divide by zero returns the dividend untouched in HI
                acc_d   = {{WIDTH{1'b0}}, bus.src0};
                dz_d    = 1'b1;
                state_d = S_FIX;
              end else begin
                acc_d   = {{WIDTH{1'b0}}, src0_mag};
                dz_d    = 1'b0;
                state_d = S_DIV;
              end
            end
            OP_MTHI: hi_d = bus.src0;
            OP_MTLO: lo_d = bus.src0;
            default: ;
          endcase
        end
      end

      S_MUL: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
`ifdef MULDIV_EARLY_OUT_EN
          if (mul_rest_zero) begin
            acc_d   = acc_q >> cnt_q;
            cnt_d   = '0;
            state_d = S_FIX;
          end else begin
            acc_d = mul_next;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_FIX;
          end
`else
          acc_d = mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
`endif
        end
      end

      S_DIV: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.cancel) begin
          done_d = 1'b1;
          if (is_mul_q) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end else if (dz_q) begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      is_mul_q  <= 1'b0;
      dz_q      <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_mul_q  <= is_mul_d;
      dz_q      <= dz_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = done_q;
  assign bus.stall = bus.busy & (bus.start | bus.hilo_rd);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, randomized ops against
// an arithmetic reference model, and hand-written multi-cycle sequences.
module tb_muldiv_sequencer;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference results straight from integer arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] mh, output logic [31:0] ml, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    logic [31:0] m;
    int          n;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 33;
    p   = '0;
    case (o)
      OP_MULT:  p = 64'(sa * sb);
      OP_MULTU: p = {32'd0, a} * {32'd0, b};
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          p   = {a, 32'hFFFF_FFFF};
          lat = 1;
        end else if (o == OP_DIV) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else begin
          p[31:0]  = a / b;
          p[63:32] = a % b;
        end
      end
      default: ;
    endcase
    if (EO && (o == OP_MULT || o == OP_MULTU)) begin
      m = (o == OP_MULT && b[31]) ? -b : b;
      n = 0;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      lat = (n + 2 > 33) ? 33 : n + 2;
    end
    mh = p[63:32];
    ml = p[31:0];
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src0  = a;
    bus.src1  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
  endtask

  // Issues an op and waits for done; lat counts edges after the issue edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output int lat, output bit busy_ok);
    issue(o, a, b);
    @(negedge clk);
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.busy) busy_ok = 1'b0;
    rhi = bus.hi;
    rlo = bus.lo;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rhi, rlo, mh, ml, a, b, hold_hi, hold_lo;
    logic [2:0]  o;
    int          lat, mlat, ndone;
    bit          bok, sok;

    tbl[0] = '{OP_MULT,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, EO ? 4 : 33};
    tbl[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, EO ? 4 : 33};
    tbl[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    tbl[3] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33};
    tbl[4] = '{OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1};
    tbl[5] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33};
    tbl[6] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         33};
    tbl[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 33};
    tbl[8] = '{OP_MULT,  32'd5,         32'd0,         32'd0,         32'd0,         EO ? 2 : 33};

    bus.start = 1'b0; bus.op = 3'd0; bus.src0 = '0; bus.src1 = '0;
    bus.cancel = 1'b0; bus.hilo_rd = 1'b0;

    #1 reset = 1'b1;
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_hi", 64'(bus.hi), 64'd0);
    chk("rst_lo", 64'(bus.lo), 64'd0);
    chk("rst_stall", 64'(bus.stall), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, rhi, rlo, lat, bok);
      chk($sformatf("vec%0d_hi", i), 64'(rhi), 64'(tbl[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(rlo), 64'(tbl[i].lo));
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("vec%0d_busy", i), 64'(bok), 64'd1);
    end

    // Randomized mul/div against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      o = 3'($urandom_range(1, 4));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 300));
        4: a = 32'($urandom_range(0, 1000));
        default: ;
      endcase
      model(o, a, b, mh, ml, mlat);
      run_op(o, a, b, rhi, rlo, lat, bok);
      chk($sformatf("rnd%0d_op%0d_hi", i, o), 64'(rhi), 64'(mh));
      chk($sformatf("rnd%0d_op%0d_lo", i, o), 64'(rlo), 64'(ml));
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(mlat));
      chk($sformatf("rnd%0d_busy", i), 64'(bok), 64'd1);
    end

    // MTHI / MTLO: one cycle, no busy, no done.
    issue(OP_MTHI, 32'h1234, 32'd0);
    chk("mthi_hi", 64'(bus.hi), 64'h1234);
    chk("mthi_done", 64'(bus.done), 64'd0);
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    issue(OP_MTLO, 32'h5678, 32'd0);
    chk("mtlo_lo", 64'(bus.lo), 64'h5678);
    chk("mtlo_hi", 64'(bus.hi), 64'h1234);

    // MFHI during MULT plus a held start: stall until the done cycle; the
    // held MTHI must be ignored while busy.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULT; bus.src0 = 32'd3; bus.src1 = 32'd4;
    bus.hilo_rd = 1'b1;
    @(posedge clk);
    #1;
    bus.op = OP_MTHI; bus.src0 = 32'hDEAD;
    sok = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!bus.done && lat < 100) begin
      if (!bus.stall) sok = 1'b0;
      if (lat == 5) bus.start = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("stall_busy", 64'(sok), 64'd1);
    chk("stall_done_cycle", 64'(bus.stall), 64'd0);
    chk("stall_hi", 64'(bus.hi), 64'd0);
    chk("stall_lo", 64'(bus.lo), 64'd12);
    chk("stall_lat", 64'(lat), EO ? 64'd5 : 64'd33);
    bus.hilo_rd = 1'b0; bus.op = 3'd0;

    // Cancel sampled at edge E+10 of a MULT.
    hold_hi = 32'd0; hold_lo = 32'd12;
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (9) @(posedge clk);
    #1 bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    chk("cancel_busy", 64'(bus.busy), 64'd0);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("cancel_no_done", 64'(ndone), 64'd0);
    chk("cancel_hi", 64'(bus.hi), 64'(hold_hi));
    chk("cancel_lo", 64'(bus.lo), 64'(hold_lo));

    // Cancel together with start in IDLE: nothing issues.
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MTHI; bus.src0 = 32'h55; bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    chk("cancel_mthi_hi", 64'(bus.hi), 64'(hold_hi));
    bus.op = OP_MULT; bus.src0 = 32'd9; bus.src1 = 32'd9;
    @(posedge clk);
    #1;
    chk("cancel_mult_busy", 64'(bus.busy), 64'd0);
    bus.start = 1'b0; bus.cancel = 1'b0; bus.op = 3'd0;

    // Cancel while in FIX on the divide-by-zero path.
    issue(OP_DIVU, 32'd77, 32'd0);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1 bus.cancel = 1'b0;
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("cancel_fix_done", 64'(ndone), 64'd0);
    chk("cancel_fix_hi", 64'(bus.hi), 64'(hold_hi));
    chk("cancel_fix_lo", 64'(bus.lo), 64'(hold_lo));

    // Asynchronous reset at E+5 of a MULT.
    issue(OP_MULT, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_hi", 64'(bus.hi), 64'd0);
    chk("midrst_lo", 64'(bus.lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Works normally again after reset.
    run_op(OP_MULTU, 32'd6, 32'd7, rhi, rlo, lat, bok);
    chk("post_rst_lo", 64'(rlo), 64'd42);
    chk("post_rst_hi", 64'(rhi), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
